// File: rtl/systolic_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : systolic_feeder
//  Purpose  : Upstream stage of the systolic MAC array. Accepts one A column
//             vector and one B row vector per beat, skews lane k by k
//             advances so operands meet diagonally in the array, drives the
//             array enable, zero-pads after the final beat until every
//             product has propagated, then pulses done.
//  Ports    : clk, rst_n (async, active-low)
//             in_valid/in_ready/in_last : beat handshake
//             a_vec[DIM], b_vec[DIM]    : signed operand vectors in
//             A[DIM], B[DIM], en        : skewed operands + enable to array
//             done (1-cycle pulse), busy (not IDLE)
//             stall_cnt[15:0]           : only with FEEDER_STALL_CNT_EN
//  Options  : FEEDER_STALL_CNT_EN -- adds a saturating count of FEED-state
//             cycles with no offered beat, cleared at job start.
//  Revision : 1.0 - initial release
// ============================================================================
module systolic_feeder #(
   parameter int BITS_AB = 8,
   parameter int DIM     = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic                      in_last,
   input  logic signed [BITS_AB-1:0] a_vec [DIM],
   input  logic signed [BITS_AB-1:0] b_vec [DIM],
   output logic signed [BITS_AB-1:0] A     [DIM],
   output logic signed [BITS_AB-1:0] B     [DIM],
   output logic                      en,
   output logic                      done,
`ifdef FEEDER_STALL_CNT_EN
   output logic                      busy,
   output logic [15:0]               stall_cnt
`else
   output logic                      busy
`endif
);

   localparam int                 CNT_W      = $clog2(2*DIM);
   // Last DRAIN count: 0..2*DIM-2 gives 2*DIM-1 zero advances, enough for
   // DIM-1 cycles of skew flush plus DIM cycles of array propagation.
   localparam logic [CNT_W-1:0]   DRAIN_LAST = CNT_W'(2*DIM-2);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FEED  = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   drain_cnt_q, drain_cnt_d;
   logic               en_q, en_d;
   logic               in_ready_q, in_ready_d;
   logic               done_q, done_d;
   logic               busy_q, busy_d;
   logic               accept;
   logic               adv;
`ifdef FEEDER_STALL_CNT_EN
   logic [15:0]        stall_cnt_q, stall_cnt_d;
`endif

   // in_ready is registered from the next state, so it always reflects
   // the current state without a combinational path from the inputs.
   assign accept = in_valid & in_ready_q;
   assign adv    = accept | (state_q == S_DRAIN);

   always_comb begin
      state_d     = state_q;
      drain_cnt_d = drain_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d     = in_last ? S_DRAIN : S_FEED;
               drain_cnt_d = '0;
            end
         end
         S_FEED: begin
            if (accept && in_last) begin
               state_d     = S_DRAIN;
               drain_cnt_d = '0;
            end
         end
         S_DRAIN: begin
            if (drain_cnt_q == DRAIN_LAST) begin
               state_d = S_DONE;
            end else begin
               drain_cnt_d = drain_cnt_q + 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      en_d       = adv;
      in_ready_d = (state_d == S_IDLE) || (state_d == S_FEED);
      done_d     = (state_d == S_DONE);
      busy_d     = (state_d != S_IDLE);
   end

`ifdef FEEDER_STALL_CNT_EN
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if ((state_q == S_IDLE) && accept) begin
         stall_cnt_d = '0;
      end else if ((state_q == S_FEED) && !in_valid && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end
   assign stall_cnt = stall_cnt_q;
`else
   // Stall counter not built in this configuration.
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         drain_cnt_q <= '0;
         en_q        <= 1'b0;
         in_ready_q  <= 1'b1;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
`ifdef FEEDER_STALL_CNT_EN
         stall_cnt_q <= '0;
`endif
      end else begin
         state_q     <= state_d;
         drain_cnt_q <= drain_cnt_d;
         en_q        <= en_d;
         in_ready_q  <= in_ready_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
`ifdef FEEDER_STALL_CNT_EN
         stall_cnt_q <= stall_cnt_d;
`endif
      end
   end

   assign en       = en_q;
   assign in_ready = in_ready_q;
   assign done     = done_q;
   assign busy     = busy_q;

   // Lane k: shift chain of k+1 registers. All chains advance together on
   // adv, so a stall freezes every lane and the diagonal stays aligned.
   for (genvar k = 0; k < DIM; k++) begin : g_lane
      logic signed [BITS_AB-1:0] a_sr_q [k+1];
      logic signed [BITS_AB-1:0] a_sr_d [k+1];
      logic signed [BITS_AB-1:0] b_sr_q [k+1];
      logic signed [BITS_AB-1:0] b_sr_d [k+1];

      always_comb begin
         a_sr_d = a_sr_q;
         b_sr_d = b_sr_q;
         if (adv) begin
            // Outside an accepted beat the only advancing state is DRAIN,
            // which feeds zeros.
            a_sr_d[0] = accept ? a_vec[k] : '0;
            b_sr_d[0] = accept ? b_vec[k] : '0;
            for (int i = 1; i <= k; i++) begin
               a_sr_d[i] = a_sr_q[i-1];
               b_sr_d[i] = b_sr_q[i-1];
            end
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int i = 0; i <= k; i++) begin
               a_sr_q[i] <= '0;
               b_sr_q[i] <= '0;
            end
         end else begin
            a_sr_q <= a_sr_d;
            b_sr_q <= b_sr_d;
         end
      end

      assign A[k] = a_sr_q[k];
      assign B[k] = b_sr_q[k];
   end

endmodule
`default_nettype wire

// File: tb/tb_systolic_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_systolic_feeder
//  Purpose  : Self-checking bench for systolic_feeder (DIM=4, BITS_AB=8).
//             Each accepted beat pushes the per-lane values expected on A/B
//             (k leading zeros, the beat data, trailing drain zeros); every
//             cycle with en=1 pops one entry per lane and compares.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_feeder;

   localparam int BITS_AB = 8;
   localparam int DIM     = 4;

   typedef logic signed [BITS_AB-1:0] vec_t [DIM];

   logic clk      = 1'b0;
   logic rst_n    = 1'b0;
   logic in_valid = 1'b0;
   logic in_last  = 1'b0;
   vec_t a_vec, b_vec, A, B;
   logic in_ready, en, done, busy;
`ifdef FEEDER_STALL_CNT_EN
   logic [15:0] stall_cnt;
`endif

   always #5 clk = ~clk;

   systolic_feeder #(.BITS_AB(BITS_AB), .DIM(DIM)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_last  (in_last),
      .a_vec    (a_vec),
      .b_vec    (b_vec),
      .A        (A),
      .B        (B),
      .en       (en),
      .done     (done),
`ifdef FEEDER_STALL_CNT_EN
      .busy     (busy),
      .stall_cnt(stall_cnt)
`else
      .busy     (busy)
`endif
   );

   // Scoreboard and reference model
   logic signed [BITS_AB-1:0] qa [DIM][$];
   logic signed [BITS_AB-1:0] qb [DIM][$];
   int  m_lock   = 0;   // remaining cycles with in_ready low (DRAIN+DONE)
   bit  m_in_job = 0;   // FEED phase
   bit  pend_acc = 0, pend_last = 0, last_acc = 0;
   int  tick_no = 0, job_start = 0, done_tick = 0;
   int  n_en = 0, n_en_low = 0, n_en_low_drain = 0, n_done = 0;
   int  total = 0, bad = 0;

   function automatic vec_t mk4(input int x0, input int x1, input int x2, input int x3);
      vec_t v;
      v[0] = 8'(x0); v[1] = 8'(x1); v[2] = 8'(x2); v[3] = 8'(x3);
      return v;
   endfunction

   task automatic reset_stats();
      n_en = 0; n_en_low = 0; n_en_low_drain = 0; n_done = 0;
   endtask

   task automatic tick();
      bit first;
      @(posedge clk); #1;
      tick_no++;
      first = pend_acc && !m_in_job;
      if (m_lock > 0) m_lock--;
      if (pend_acc) begin
         if (first) job_start = tick_no;
         if (pend_last) begin
            m_lock   = 2*DIM;
            m_in_job = 0;
         end else begin
            m_in_job = 1;
         end
      end
      pend_acc = 0; pend_last = 0;
      if (m_in_job || m_lock > 0) begin
         if (en === 1'b1) n_en++;
         else begin
            n_en_low++;
            if (m_lock > 0) n_en_low_drain++;
         end
      end
      if (done === 1'b1) begin
         n_done++;
         done_tick = tick_no;
      end
   endtask

   task automatic offer(input bit v, input bit l, input vec_t av, input vec_t bv);
      in_valid = v; in_last = l; a_vec = av; b_vec = bv;
      last_acc = v && (m_lock == 0);
      if (last_acc) begin
         if (!m_in_job)
            for (int k = 0; k < DIM; k++)
               for (int z = 0; z < k; z++) begin qa[k].push_back('0); qb[k].push_back('0); end
         for (int k = 0; k < DIM; k++) begin qa[k].push_back(av[k]); qb[k].push_back(bv[k]); end
         if (l)
            for (int k = 0; k < DIM; k++)
               for (int z = 0; z < 2*DIM-1-k; z++) begin qa[k].push_back('0); qb[k].push_back('0); end
         pend_acc = 1; pend_last = l;
      end
      tick();
   endtask

   task automatic idle(input int n);
      in_valid = 0; in_last = 0;
      for (int i = 0; i < n; i++) tick();
   endtask

   // Per-cycle monitor: handshake/status against the model, A/B against the
   // scoreboard whenever the array is enabled.
   always @(negedge clk) begin
      if (rst_n) begin
         total++;
         if (in_ready !== (m_lock == 0)) begin
            bad++; $display("FAIL in_ready t=%0d: got %b want %b", tick_no, in_ready, (m_lock == 0));
         end
         total++;
         if (done !== (m_lock == 1)) begin
            bad++; $display("FAIL done t=%0d: got %b want %b", tick_no, done, (m_lock == 1));
         end
         total++;
         if (busy !== (m_in_job || m_lock > 0)) begin
            bad++; $display("FAIL busy t=%0d: got %b want %b", tick_no, busy, (m_in_job || m_lock > 0));
         end
         if (en === 1'b1) begin
            for (int k = 0; k < DIM; k++) begin
               logic signed [BITS_AB-1:0] ea, eb;
               total++;
               if (qa[k].size() == 0 || qb[k].size() == 0) begin
                  bad++; $display("FAIL sb_underflow lane %0d t=%0d: en=1 with no expected data", k, tick_no);
               end else begin
                  ea = qa[k].pop_front();
                  eb = qb[k].pop_front();
                  if (A[k] !== ea || B[k] !== eb) begin
                     bad++;
                     $display("FAIL lane%0d t=%0d: got A=%0d B=%0d want A=%0d B=%0d", k, tick_no, A[k], B[k], ea, eb);
                  end
               end
            end
         end
      end
   end

   task automatic check_empty(input string name);
      int left = 0;
      for (int k = 0; k < DIM; k++) left += qa[k].size() + qb[k].size();
      total++;
      if (left != 0) begin bad++; $display("FAIL %s_sb_left: got %0d entries want 0", name, left); end
   endtask

   task automatic check_job(input string name, input int k_beats, input int stalls);
      total++;
      if (n_en != k_beats + 2*DIM - 1) begin bad++; $display("FAIL %s_en_count: got %0d want %0d", name, n_en, k_beats + 2*DIM - 1); end
      total++;
      if (n_done != 1) begin bad++; $display("FAIL %s_done_count: got %0d want 1", name, n_done); end
      total++;
      if (done_tick - job_start != k_beats + 2*DIM - 2 + stalls) begin
         bad++; $display("FAIL %s_done_time: got %0d want %0d", name, done_tick - job_start, k_beats + 2*DIM - 2 + stalls);
      end
      total++;
      if (n_en_low != stalls) begin bad++; $display("FAIL %s_en_low: got %0d want %0d", name, n_en_low, stalls); end
      check_empty(name);
   endtask

   task automatic test_reset();
      bit nz = 0;
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < DIM; k++) if (A[k] !== '0 || B[k] !== '0) nz = 1;
      total++; if (nz) begin bad++; $display("FAIL reset_AB: got nonzero want 0"); end
      total++; if (en !== 1'b0)       begin bad++; $display("FAIL reset_en: got %b want 0", en); end
      total++; if (done !== 1'b0)     begin bad++; $display("FAIL reset_done: got %b want 0", done); end
      total++; if (busy !== 1'b0)     begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      #2 rst_n = 1'b1;
      idle(2);
   endtask

   task automatic test_single();
      reset_stats();
      offer(1, 1, mk4(1, 2, 3, 4), mk4(5, 6, 7, 8));
      total++; if (A[0] !== 8'sd1 || B[0] !== 8'sd5) begin bad++; $display("FAIL single_lane0: got A=%0d B=%0d want 1 5", A[0], B[0]); end
      total++; if (en !== 1'b1) begin bad++; $display("FAIL single_en_first: got %b want 1", en); end
      idle(2);
      total++; if (B[2] !== 8'sd7) begin bad++; $display("FAIL single_B2: got %0d want 7", B[2]); end
      idle(1);
      total++; if (A[3] !== 8'sd4) begin bad++; $display("FAIL single_A3: got %0d want 4", A[3]); end
      idle(10);
      check_job("single", 1, 0);
   endtask

   task automatic test_burst();
      int lo = 0;
      reset_stats();
      for (int i = 0; i < 4; i++) offer(1, i == 3, mk4(i, -i, 10+i, 20+i), mk4(30+i, 40+i, -50-i, i*3));
      for (int i = 0; i < 20 && in_ready === 1'b0; i++) begin lo++; idle(1); end
      total++; if (lo != 2*DIM) begin bad++; $display("FAIL burst_ready_low: got %0d want %0d", lo, 2*DIM); end
      total++; if (done_tick != tick_no - 1) begin bad++; $display("FAIL burst_ready_after_done: got %0d want %0d", done_tick, tick_no - 1); end
      idle(4);
      check_job("burst", 4, 0);
   endtask

   task automatic test_stall();
      reset_stats();
      offer(1, 0, mk4(11, 12, 13, 14), mk4(15, 16, 17, 18));
      idle(2);
      offer(1, 0, mk4(21, 22, 23, 24), mk4(25, 26, 27, 28));
      offer(1, 1, mk4(31, 32, 33, 34), mk4(35, 36, 37, 38));
      idle(12);
      check_job("stall", 3, 2);
      total++; if (n_en_low_drain != 0) begin bad++; $display("FAIL stall_en_low_in_drain: got %0d want 0", n_en_low_drain); end
`ifdef FEEDER_STALL_CNT_EN
      total++; if (stall_cnt !== 16'd2) begin bad++; $display("FAIL stall_cnt: got %0d want 2", stall_cnt); end
`endif
   endtask

   task automatic test_drain_valid();
      reset_stats();
      offer(1, 0, mk4(1, -1, 2, -2), mk4(3, -3, 4, -4));
      offer(1, 1, mk4(5, -5, 6, -6), mk4(7, -7, 8, -8));
      // Junk offered for every DRAIN/DONE cycle must be ignored.
      for (int i = 0; i < 2*DIM; i++) offer(1, i[0], mk4(99, 98, 97, 96), mk4(-99, -98, -97, -96));
      idle(4);
      check_job("drain_valid", 2, 0);
   endtask

   task automatic test_reset_mid_drain();
      bit nz = 0;
      reset_stats();
      offer(1, 0, mk4(7, 7, 7, 7), mk4(9, 9, 9, 9));
      offer(1, 1, mk4(8, 8, 8, 8), mk4(6, 6, 6, 6));
      idle(3);
      #2 rst_n = 1'b0;
      #1;
      for (int k = 0; k < DIM; k++) if (A[k] !== '0 || B[k] !== '0) nz = 1;
      total++; if (nz) begin bad++; $display("FAIL midrst_AB: got nonzero want 0"); end
      total++; if (en !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL midrst_ctrl: got en=%b done=%b busy=%b want 0 0 0", en, done, busy);
      end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
      for (int k = 0; k < DIM; k++) begin qa[k].delete(); qb[k].delete(); end
      m_lock = 0; m_in_job = 0; pend_acc = 0; pend_last = 0;
      @(posedge clk);
      #3 rst_n = 1'b1;
      idle(4);
      total++; if (n_done != 0) begin bad++; $display("FAIL midrst_no_done: got %0d want 0", n_done); end
      reset_stats();
      offer(1, 1, mk4(4, 3, 2, 1), mk4(-4, -3, -2, -1));
      idle(10);
      check_job("after_rst", 1, 0);
   endtask

   task automatic test_signed();
      reset_stats();
      offer(1, 0, mk4(-128, 127, -128, 127), mk4(127, -128, 127, -128));
      offer(1, 0, mk4(-1, 0, -128, 127), mk4(127, -128, -1, 0));
      offer(1, 1, mk4(127, 127, -128, -128), mk4(-128, -128, 127, 127));
      idle(12);
      check_job("signed", 3, 0);
   endtask

   task automatic test_back_to_back();
      int d1;
      bit got = 0;
      reset_stats();
      offer(1, 0, mk4(1, 1, 1, 1), mk4(2, 2, 2, 2));
      offer(1, 1, mk4(3, 3, 3, 3), mk4(4, 4, 4, 4));
      for (int i = 0; i < 20 && !got; i++) begin
         offer(1, 0, mk4(-5, -6, -7, -8), mk4(5, 6, 7, 8));
         got = last_acc;
      end
      d1 = done_tick;
      total++; if (!got) begin bad++; $display("FAIL b2b_accept_timeout: got none want accept"); end
      // DONE occupies period d1, IDLE the next; the beat is taken at the
      // edge closing that IDLE period.
      total++; if (job_start != d1 + 2) begin bad++; $display("FAIL b2b_start: got %0d want %0d", job_start, d1 + 2); end
      offer(1, 1, mk4(-9, 10, -11, 12), mk4(13, -14, 15, -16));
      idle(12);
      total++; if (n_done != 2) begin bad++; $display("FAIL b2b_done_count: got %0d want 2", n_done); end
      check_empty("b2b");
   endtask

   initial begin
      a_vec = mk4(0, 0, 0, 0);
      b_vec = mk4(0, 0, 0, 0);
      test_reset();
      test_single();
      test_burst();
      test_stall();
      test_drain_valid();
      test_reset_mid_drain();
      test_signed();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
